// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: execute stage <-> word-addressed data RAM.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses instead of faulting.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_fault,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] o_mem_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int DW  = DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int LNB = $clog2(NB);
  localparam int WA  = ADDR_WIDTH - LNB;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_w0;
  logic [DW-1:0]         r_rdata;
  logic [1:0]            r_fault;
  logic                  r_cross;

  logic                  w_idle;
  logic                  w_we;
  logic [2:0]            w_f3;
  logic [LNB-1:0]        w_off;
  logic [3:0]            w_off4;
  logic [3:0]            w_size;
  logic [6:0]            w_bits;
  logic                  w_illegal;
  logic                  w_mis;
  logic                  w_cross;
  logic [DW-1:0]         w_mdw;
  logic [DW-1:0]         w_top;
  logic [DW-1:0]         w_lo;
  logic [DW-1:0]         w_hi;
  logic [2*DW-1:0]       w_sh;
  logic [DW-1:0]         w_val;
  logic [DW-1:0]         w_ext;
  logic [2*DW-1:0]       w_wide;
  logic [NB-1:0]         w_bm;
  logic [2*NB-1:0]       w_bew;
  logic                  w_hib;
  logic [WA-1:0]         w_wa;

  // Decode from the request in IDLE, from the latched access otherwise
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_we      = w_idle ? i_we : r_we;
    w_f3      = w_idle ? i_funct3 : r_f3;
    w_off     = w_idle ? i_addr[LNB-1:0] : r_addr[LNB-1:0];
    w_off4    = 4'(w_off);
    w_size    = 4'd1 << w_f3[1:0];
    w_bits    = {w_size, 3'b000};
    w_illegal = (w_f3 == 3'b111)
              || (DW == 32 && w_f3 == 3'b011)
              || (w_we && w_f3[2]);
    w_mis     = |(w_off4 & (w_size - 4'd1));
    w_cross   = ({1'b0, w_off4} + {1'b0, w_size}) > 5'(NB);
    w_mdw     = (w_bits >= 7'(DW)) ? '1 : ~({DW{1'b1}} << w_bits);
    w_top     = w_mdw ^ (w_mdw >> 1);
    w_lo      = (r_state == S_ACC1) ? r_w0 : i_mem_rdata;
    w_hi      = (r_state == S_ACC1) ? i_mem_rdata : '0;
    w_sh      = {w_hi, w_lo} >> {w_off, 3'b000};
    w_val     = w_sh[DW-1:0] & w_mdw;
    w_ext     = (!w_f3[2] && |(w_val & w_top)) ? (w_val | ~w_mdw) : w_val;
    w_wide    = {{DW{1'b0}}, r_wdata & w_mdw} << {w_off, 3'b000};
    w_bm      = (w_size >= 4'(NB)) ? '1 : ~({NB{1'b1}} << w_size);
    w_bew     = {{NB{1'b0}}, w_bm} << w_off;
    w_hib     = (r_state == S_ACC1);
    w_wa      = r_addr[ADDR_WIDTH-1:LNB];
  end

  always_comb begin
    o_ready     = w_idle;
    o_done      = (r_state == S_RESP);
    o_rdata     = o_done ? r_rdata : '0;
    o_fault     = o_done ? r_fault : 2'b00;
    o_mem_req   = (r_state == S_ACC0) || w_hib;
    o_mem_we    = o_mem_req && r_we;
    o_mem_addr  = '0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    if (o_mem_req)
      o_mem_addr = w_hib ? w_wa + WA'(1) : w_wa;
    if (o_mem_we) begin
      o_mem_be    = w_hib ? w_bew[2*NB-1:NB] : w_bew[NB-1:0];
      o_mem_wdata = w_hib ? w_wide[2*DW-1:DW] : w_wide[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_w0    <= '0;
      r_rdata <= '0;
      r_fault <= 2'b00;
      r_cross <= 1'b0;
    end else if (clk_en) begin
      unique case (r_state)
        S_IDLE: if (i_req) begin
          r_we    <= i_we;
          r_f3    <= i_funct3;
          r_addr  <= i_addr;
          r_wdata <= i_wdata;
          r_rdata <= '0;
          r_fault <= 2'b00;
          r_cross <= w_cross;
          if (w_illegal) begin
            r_fault <= 2'b10;
            r_state <= S_RESP;
          end else if (w_mis && !SPLIT) begin
            r_fault <= 2'b01;
            r_state <= S_RESP;
          end else begin
            r_state <= S_ACC0;
          end
        end
        S_ACC0: if (i_mem_ready) begin
          r_w0 <= i_mem_rdata;
          if (r_cross) begin
            r_state <= S_ACC1;
          end else begin
            r_rdata <= r_we ? '0 : w_ext;
            r_state <= S_RESP;
          end
        end
        S_ACC1: if (i_mem_ready) begin
          r_rdata <= r_we ? '0 : w_ext;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
